// File: rtl/generator_sched_pkg.sv
// Shared types and helpers for the generator scheduler and its round-robin arbiter.
package generator_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SKIP  = 2'd2,
    RUN   = 2'd3
  } state_t;

  localparam int DEFAULT_WIDTH = 32;

  // Index width for n requesters; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/generator_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr, wrapping at N.
module rr_arbiter
  import generator_sched_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = |req;
    cand  = 0;
    // Walk from the farthest offset to the nearest so the nearest request wins.
    for (int off = N - 1; off >= 0; off--) begin
      cand = int'(ptr) + off;
      if (cand >= N) cand = cand - N;
      if (req[cand[IW-1:0]]) idx = cand[IW-1:0];
    end
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/generator_scheduler.sv
// Shares one generator core between N_REQ requesters in round-robin order.
// Optional watchdog abort is compiled in with GENERATOR_SCHEDULER_WATCHDOG_EN.
module generator_scheduler
  import generator_sched_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int N_ARGS     = 4,
  parameter int N_OUTS     = 4,
  parameter int MAX_CYCLES = 1024,
  localparam int IW = idx_width(N_REQ),
  localparam int AW = N_ARGS * WIDTH,
  localparam int OW = N_OUTS * WIDTH
) (
  input  logic                _clock,
  input  logic                _reset,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*AW-1:0] req_args,
  output logic [N_REQ-1:0]    req_ack,
  output logic                gen_start,
  output logic [AW-1:0]       gen_args,
  input  logic [OW-1:0]       gen_out,
  input  logic                gen_done,
  output logic                out_valid,
  output logic [OW-1:0]       out_data,
  output logic [IW-1:0]       out_id,
  output logic                busy,
  output logic                err,
  output state_t              state
);

  // Handshake: req_valid[r] is a level held until req_ack[r] pulses for one
  // cycle; req_args slice r must be stable while req_valid[r] is high. The
  // output stream has no backpressure: out_valid is a one-cycle strobe.

  state_t           state_d;
  logic [IW-1:0]    cur, cur_d, ptr, ptr_d, cur_inc;
  logic [AW-1:0]    args_d;
  logic             start_d, valid_d;
  logic [N_REQ-1:0] ack_d;
  logic [OW-1:0]    data_d;
  logic [IW-1:0]    id_d;
  logic [N_REQ-1:0] grant;
  logic [IW-1:0]    grant_idx;
  logic             grant_any;
  logic             wd_hit;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  assign cur_inc = (int'(cur) == N_REQ - 1) ? '0 : cur + IW'(1);
  assign busy    = (state != IDLE);

`ifdef GENERATOR_SCHEDULER_WATCHDOG_EN
  localparam int CW = $clog2(MAX_CYCLES + 1);
  logic [CW-1:0] wd_cnt;
  logic          err_q;
  logic          wd_abort;

  assign wd_hit   = (wd_cnt == CW'(MAX_CYCLES - 1));
  assign wd_abort = (state == RUN) && !gen_done && wd_hit;
  assign err      = err_q;

  always_ff @(posedge _clock) begin
    if (_reset) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == START) wd_cnt <= '0;
      else if (state == RUN && !gen_done) wd_cnt <= wd_cnt + CW'(1);
      if (wd_abort) err_q <= 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = (MAX_CYCLES > 0);
  assign wd_hit     = 1'b0;
  assign err        = 1'b0;
`endif

  always_comb begin
    state_d = state;
    cur_d   = cur;
    ptr_d   = ptr;
    args_d  = gen_args;
    start_d = 1'b0;
    ack_d   = '0;
    valid_d = 1'b0;
    data_d  = out_data;
    id_d    = out_id;
    unique case (state)
      IDLE: begin
        if (grant_any) begin
          cur_d   = grant_idx;
          args_d  = '0;
          for (int r = 0; r < N_REQ; r++)
            if (grant[r]) args_d = req_args[r*AW +: AW];
          start_d = 1'b1;
          state_d = START;
        end
      end
      START: state_d = SKIP;
      // Generator outputs still reflect the previous job during this cycle.
      SKIP:  state_d = RUN;
      RUN: begin
        if (gen_done) begin
          ack_d[cur] = 1'b1;
          ptr_d      = cur_inc;
          state_d    = IDLE;
        end else if (wd_hit) begin
          start_d    = 1'b1;
          ack_d[cur] = 1'b1;
          ptr_d      = cur_inc;
          state_d    = IDLE;
        end else begin
          data_d  = gen_out;
          id_d    = cur;
          valid_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge _clock) begin
    if (_reset) begin
      state     <= IDLE;
      cur       <= '0;
      ptr       <= '0;
      gen_start <= 1'b1;
      gen_args  <= '0;
      req_ack   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
    end else begin
      state     <= state_d;
      cur       <= cur_d;
      ptr       <= ptr_d;
      gen_start <= start_d;
      gen_args  <= args_d;
      req_ack   <= ack_d;
      out_valid <= valid_d;
      out_data  <= data_d;
      out_id    <= id_d;
    end
  end

endmodule

// File: doc/generator_scheduler.md
Name: generator_scheduler

Overview:
- Round-robin scheduler that shares one Python2Verilog-generated generator instance between N_REQ requesters.
- Each requester supplies an argument tuple. The scheduler loads the tuple, pulses the generator's `_start`, and forwards every yielded output tuple downstream tagged with the requester ID.
- When the generator's `_done` rises it acknowledges the requester, then moves to the next pending requester.
- Sits between the host/bridge logic and a single generator core.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- WIDTH, 32, signed width of each argument and output element
- N_ARGS, 4, arguments per generator call
- N_OUTS, 4, output elements per yielded tuple
- MAX_CYCLES, 1024, watchdog limit (used only with the optional feature)

Ports:
- _clock  in  1  single system clock
- _reset  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  per-requester job request; level, held until ack
- req_args  in  N_REQ*N_ARGS*WIDTH  packed argument tuples; requester r at slice r; stable while req_valid[r]
- req_ack  out  N_REQ  one-cycle one-hot pulse when requester's job completes
- gen_start  out  1  drives generator `_start`
- gen_args  out  N_ARGS*WIDTH  drives generator argument inputs
- gen_out  in  N_OUTS*WIDTH  generator `_out0.._outN`
- gen_done  in  1  generator `_done`
- out_valid  out  1  one-cycle strobe per yielded tuple; no backpressure
- out_data  out  N_OUTS*WIDTH  captured tuple
- out_id  out  max(1,$clog2(N_REQ))  requester owning out_data
- busy  out  1  high in any state other than IDLE
- err  out  1  watchdog abort flag (0 when the feature is compiled out)

Behaviour:
- Reset values (while _reset=1, and on the first edge after):
  - state=IDLE, rr pointer=0.
  - gen_start=1, which holds the generator in its own start/reset.
  - req_ack=0, out_valid=0, out_data=0, out_id=0, busy=0, err=0.
  - gen_args=0.
- State machine (all outputs registered):
  - IDLE: gen_start=0. If any req_valid is set, pick the first set bit at or after rr pointer, wrapping around. Latch its index to cur and its args to gen_args. Go to START.
  - START: gen_start=1 for exactly one cycle. Go to SKIP.
  - SKIP: one cycle. gen_out and gen_done are stale here and ignored. Go to RUN.
  - RUN, on each edge:
    - If gen_done=0: capture gen_out to out_data, out_id=cur, out_valid=1.
    - If gen_done=1: out_valid=0, req_ack[cur]=1, rr pointer=cur+1 (mod N_REQ). Go to IDLE.
- Latency:
  - Grant to gen_start: 1 cycle after req_valid is seen in IDLE.
  - First out_valid: 3 cycles after the gen_start cycle.
  - Job-to-job turnaround: done edge → IDLE → next START, i.e. 2 cycles of gap.
- gen_args stay constant from grant until the return to IDLE. Requester arg changes during that window are ignored.
- A requester that deasserts req_valid mid-job is still run to completion and acked.
- A requester may re-request on the cycle after its ack. It is served only after all other pending requesters (fairness).
- Simultaneous requests: rr order decides; the lowest index at or after the pointer wins.
- Zero-yield generator (done already in the first RUN cycle): no out_valid, ack still pulses.
- Reset mid-RUN: abort immediately, no ack, pending requests re-arbitrated from pointer 0.
- Arithmetic: rr pointer wraps at N_REQ (not at a power of two). Tuples pass through unmodified, sign preserved.

Optional Feature:
- Macro: GENERATOR_SCHEDULER_WATCHDOG_EN.
- Defined:
  - A cycle counter clears at START and counts in RUN.
  - Reaching MAX_CYCLES without gen_done: force gen_start=1 for one cycle (aborts the generator), set err=1 (sticky until _reset), pulse req_ack[cur], go to IDLE.
  - out_valid is suppressed in the abort cycle.
- Undefined: no counter; err tied to 0; RUN waits indefinitely.

Decomposition:
- Package generator_sched_pkg:
  - State enum {IDLE, START, SKIP, RUN}.
  - WIDTH default constant.
  - Function for index width.
- Sub-module rr_arbiter:
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, encoded index, any-valid.
  - Combinational.
  - Reusable by other shared-core schedulers.

Test Plan:
- Single request: N_REQ=4, generator yields (a,b),(c,d). req_valid=0001 with args (1,2,3,4) → out_valid twice with data (1,2),(3,4), out_id=0; req_ack=0001 one cycle after the second tuple. First out_valid 3 cycles after gen_start.
- Contention: req_valid=1011, pointer 0 → service order 0,1,3. Requester 0 re-requesting right after its ack is served after 3, not before 1.
- Wrap-around: pointer=3 after serving 2, req_valid=1001 → requester 3 then 0.
- Arg stability: change req_args of the active requester mid-RUN → out_data reflects the latched args. Deassert req_valid mid-job → job completes and acks.
- Reset mid-RUN: assert _reset for one cycle during the second tuple → no ack, gen_start=1 during reset, busy=0, next grant starts from requester 0.
- Watchdog (macro defined, MAX_CYCLES=8): generator never asserts done → err=1, req_ack[cur] pulses, gen_start pulses at cycle 8 of RUN. Next requester runs normally.
